// File: rtl/agu_seq.sv
// agu_seq: job sequencer that clears an agu, steps it under valid/ready back-pressure
// and emits base-offset addresses framed with last/done.
module agu_seq #(
  parameter int BWADDR   = 21,
  parameter int BWLENGTH = 8,
  parameter int BWREP    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BWADDR-1:0]   cfg_base,
  input  logic [BWLENGTH-1:0] cfg_l0,
  input  logic [BWLENGTH-1:0] cfg_l1,
  input  logic [BWLENGTH-1:0] cfg_l2,
  input  logic [BWADDR-1:0]   cfg_j0,
  input  logic [BWADDR-1:0]   cfg_j1,
  input  logic [BWADDR-1:0]   cfg_j2,
  input  logic [BWADDR-1:0]   cfg_j3,
  input  logic [BWREP-1:0]    cfg_n3,
  output logic                busy,
  output logic                done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BWADDR-1:0]   out_addr,
  output logic                out_last,
  output logic                agu_clr,
  output logic                agu_step,
  output logic [BWLENGTH-1:0] agu_l0,
  output logic [BWLENGTH-1:0] agu_l1,
  output logic [BWLENGTH-1:0] agu_l2,
  output logic [BWADDR-1:0]   agu_j0,
  output logic [BWADDR-1:0]   agu_j1,
  output logic [BWADDR-1:0]   agu_j2,
  output logic [BWADDR-1:0]   agu_j3,
  input  logic [BWADDR-1:0]   agu_addr,
  input  logic                agu_z0,
  input  logic                agu_z1,
  input  logic                agu_z2
);
  typedef enum logic [1:0] {IDLE, CLR, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [BWADDR-1:0]   r_base;
  logic [BWREP-1:0]    r_rem;
  logic                w_wrap, w_hs, w_end;
  assign busy     = r_state != IDLE;
  assign agu_clr  = r_state == CLR;
  assign agu_step = r_state == RUN && !abort && (!out_valid || out_ready);
  assign w_wrap   = agu_z0 & agu_z1 & agu_z2;
  assign w_hs     = out_valid & out_ready;
  assign w_end    = w_wrap && r_rem == '0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? CLR : IDLE;
      CLR:     w_next = RUN;
      RUN:     w_next = (agu_step && w_end) ? DRAIN : RUN;
      DRAIN:   w_next = w_hs ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Abort wins over start and over a handshake in flight; the dropped beat is never retried.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_addr  <= '0;
      r_base    <= '0;
      r_rem     <= '0;
      agu_l0    <= '0;
      agu_l1    <= '0;
      agu_l2    <= '0;
      agu_j0    <= '0;
      agu_j1    <= '0;
      agu_j2    <= '0;
      agu_j3    <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (r_state == IDLE && start) begin
        r_base <= cfg_base;
        r_rem  <= cfg_n3;
        agu_l0 <= cfg_l0;
        agu_l1 <= cfg_l1;
        agu_l2 <= cfg_l2;
        agu_j0 <= cfg_j0;
        agu_j1 <= cfg_j1;
        agu_j2 <= cfg_j2;
        agu_j3 <= cfg_j3;
      end else if (agu_step) begin
        out_valid <= 1'b1;
        out_addr  <= r_base + agu_addr;
        out_last  <= w_end;
        if (w_wrap && !w_end) r_rem <= r_rem - BWREP'(1);
      end else if (r_state == DRAIN && w_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end
    end
endmodule

// File: tb/tb_agu_seq.sv
// tb_agu_seq: drives agu_seq against a stub agu and a closed-form address model.
module tb_agu_seq;
  logic        clk = 1'b0, rst_n, start, abort, out_ready;
  logic [20:0] cfg_base, cfg_j0, cfg_j1, cfg_j2, cfg_j3;
  logic [7:0]  cfg_l0, cfg_l1, cfg_l2, cfg_n3;
  logic        busy, done, out_valid, out_last, agu_clr, agu_step;
  logic [20:0] out_addr, agu_addr, agu_j0, agu_j1, agu_j2, agu_j3;
  logic [7:0]  agu_l0, agu_l1, agu_l2;
  logic        agu_z0, agu_z1, agu_z2;
  int n_cmp = 0, n_fail = 0;

  agu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_base(cfg_base),
    .cfg_l0(cfg_l0), .cfg_l1(cfg_l1), .cfg_l2(cfg_l2),
    .cfg_j0(cfg_j0), .cfg_j1(cfg_j1), .cfg_j2(cfg_j2), .cfg_j3(cfg_j3), .cfg_n3(cfg_n3),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_last(out_last), .agu_clr(agu_clr), .agu_step(agu_step),
    .agu_l0(agu_l0), .agu_l1(agu_l1), .agu_l2(agu_l2),
    .agu_j0(agu_j0), .agu_j1(agu_j1), .agu_j2(agu_j2), .agu_j3(agu_j3),
    .agu_addr(agu_addr), .agu_z0(agu_z0), .agu_z1(agu_z1), .agu_z2(agu_z2)
  );

  always #5 clk = ~clk;

  // Stub agu: nested counters, innermost first, each wrap adds the next level's jump.
  logic [7:0]  s0, s1, s2;
  logic [20:0] sa;
  assign agu_addr = sa;
  assign agu_z0 = agu_step && s0 == agu_l0;
  assign agu_z1 = agu_step && s1 == agu_l1;
  assign agu_z2 = agu_step && s2 == agu_l2;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0 <= '0; s1 <= '0; s2 <= '0; sa <= '0;
    end else if (agu_clr) begin
      s0 <= '0; s1 <= '0; s2 <= '0; sa <= '0;
    end else if (agu_step) begin
      if (s0 != agu_l0) begin s0 <= s0 + 8'd1; sa <= sa + agu_j0; end
      else begin
        s0 <= '0;
        if (s1 != agu_l1) begin s1 <= s1 + 8'd1; sa <= sa + agu_j1; end
        else begin
          s1 <= '0;
          if (s2 != agu_l2) begin s2 <= s2 + 8'd1; sa <= sa + agu_j2; end
          else begin s2 <= '0; sa <= sa + agu_j3; end
        end
      end
    end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: beat (r,a,b,c) lands at base + r*D3 + a*D2 + b*D1 + c*D0, mod 2^21.
  logic [20:0] exp_a[$], acc_q[$];
  bit          exp_l[$];
  function automatic void gen(input logic [20:0] b, input logic [7:0] l0, l1, l2,
                              input logic [20:0] j0, j1, j2, j3, input logic [7:0] n3);
    logic [20:0] d0, d1, d2, d3;
    d0 = j0;
    d1 = 21'(l0) * d0 + j1;
    d2 = 21'(l1) * d1 + 21'(l0) * d0 + j2;
    d3 = 21'(l2) * d2 + 21'(l1) * d1 + 21'(l0) * d0 + j3;
    for (int r = 0; r <= int'(n3); r++)
      for (int a = 0; a <= int'(l2); a++)
        for (int y = 0; y <= int'(l1); y++)
          for (int c = 0; c <= int'(l0); c++) begin
            exp_a.push_back(b + 21'(r) * d3 + 21'(a) * d2 + 21'(y) * d1 + 21'(c) * d0);
            exp_l.push_back(r == int'(n3) && a == int'(l2) && y == int'(l1) && c == int'(l0));
          end
  endfunction

  bit           m_busy, m_done;
  int           m_since;
  logic [107:0] m_cfg;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_since = 0;
      exp_a.delete(); exp_l.delete();
    end else begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("valid", out_valid, m_busy && m_since >= 3);
      chk("clr", agu_clr, m_busy && m_since == 1);
      chk("step", agu_step, m_busy && m_since >= 2 && !abort &&
          !(out_valid && (!out_ready || exp_a.size() == 1)));
      if (m_busy)
        chk("agu_cfg", {agu_l0, agu_l1, agu_l2, agu_j0, agu_j1, agu_j2, agu_j3}, m_cfg);
      if (out_valid) begin
        chk("beat_avail", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) begin
          chk("addr", out_addr, exp_a[0]);
          chk("last", out_last, exp_l[0]);
        end
      end
      m_done = 0;
      if (abort) begin
        m_busy = 0;
        exp_a.delete(); exp_l.delete();
      end else if (m_busy) begin
        m_since++;
        if (out_valid && out_ready && exp_a.size() > 0) begin
          acc_q.push_back(out_addr);
          if (exp_a.size() == 1) begin m_busy = 0; m_done = 1; end
          void'(exp_a.pop_front()); void'(exp_l.pop_front());
        end
      end else if (start) begin
        m_busy = 1; m_since = 1;
        m_cfg = {cfg_l0, cfg_l1, cfg_l2, cfg_j0, cfg_j1, cfg_j2, cfg_j3};
        gen(cfg_base, cfg_l0, cfg_l1, cfg_l2, cfg_j0, cfg_j1, cfg_j2, cfg_j3, cfg_n3);
      end
    end
  end

  int vec_exp [8] = '{256, 257, 267, 268, 1268, 1269, 1279, 1280};

  task automatic set_cfg(input logic [20:0] b, input logic [7:0] l0, l1, l2,
                         input logic [20:0] j0, j1, j2, j3, input logic [7:0] n3);
    cfg_base = b; cfg_l0 = l0; cfg_l1 = l1; cfg_l2 = l2;
    cfg_j0 = j0; cfg_j1 = j1; cfg_j2 = j2; cfg_j3 = j3; cfg_n3 = n3;
  endtask

  task automatic set_vec();
    set_cfg(21'h100, 1, 1, 0, 1, 10, 100, 1000, 1);
  endtask

  task automatic chk_vec(input string nm);
    chk({nm, "_beats"}, acc_q.size(), 8);
    for (int i = 0; i < 8 && i < acc_q.size(); i++) chk(nm, acc_q[i], vec_exp[i]);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_clr"}, agu_clr, 0);
    chk({nm, "_step"}, agu_step, 0);
    chk({nm, "_addr"}, out_addr, 0);
    chk({nm, "_l0"}, agu_l0, 0);
  endtask

  // mode: 0 ready, 1 stall at beat 3, 2 abort after beat 2, 3 spurious start,
  // 4 async reset after beat 3, 5 random ready/start (+abort when rab)
  task automatic run_job(input int mode, input bit rab);
    int cyc = 0, stall = 5;
    bit ab = 0;
    acc_q.delete();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    while (m_busy && cyc < 3000) begin
      cyc++;
      out_ready = 1; abort = 0; start = 0;
      if (mode == 1 && acc_q.size() == 2 && stall > 0) begin out_ready = 0; stall--; end
      if (mode == 2 && acc_q.size() == 2 && !ab) begin abort = 1; ab = 1; end
      if (mode == 3 && cyc == 4) begin
        start = 1;
        set_cfg(21'($urandom), 3, 2, 1, 21'($urandom), 21'($urandom), 5, 6, 3);
      end
      if (mode == 5) begin
        out_ready = $urandom_range(0, 9) < 7;
        abort = rab && $urandom_range(0, 99) < 2;
        start = $urandom_range(0, 9) == 0;
      end
      if (mode == 4 && acc_q.size() == 3) begin
        #2 rst_n = 0;
        #1 chk_zero("async_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        break;
      end
      @(posedge clk); #1;
    end
    abort = 0; start = 0; out_ready = 1;
    chk("job_end", m_busy, 0);
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; out_ready = 1;
    set_vec();
    gen(cfg_base, cfg_l0, cfg_l1, cfg_l2, cfg_j0, cfg_j1, cfg_j2, cfg_j3, cfg_n3);
    chk("model_n", exp_a.size(), 8);
    for (int i = 0; i < 8 && i < exp_a.size(); i++) begin
      chk("model_addr", exp_a[i], vec_exp[i]);
      chk("model_last", exp_l[i], i == 7);
    end
    exp_a.delete(); exp_l.delete();
    #12 chk_zero("reset");
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk);
    run_job(0, 0);
    chk_vec("full_rate");
    repeat (3) @(posedge clk);
    run_job(1, 0);
    chk_vec("stall");
    set_cfg(7, 0, 0, 0, 3, 4, 5, 6, 0);
    run_job(0, 0);
    chk("single_n", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("single_addr", acc_q[0], 7);
    set_vec();
    run_job(2, 0);
    chk("abort_beats", acc_q.size(), 2);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    run_job(0, 0);
    chk_vec("after_abort");
    run_job(3, 0);
    chk_vec("spurious_start");
    set_vec();
    run_job(4, 0);
    repeat (4) @(posedge clk);
    run_job(0, 0);
    chk_vec("after_reset");
    for (int k = 0; k < 40; k++) begin
      set_cfg(21'($urandom), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
              8'($urandom_range(0, 3)), 21'($urandom), 21'($urandom), 21'($urandom),
              21'($urandom), 8'($urandom_range(0, 2)));
      run_job(5, k[0]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
